// File: rtl/updown_mod_counter_pkg.sv
// Shared types for the up/down modulo counter: boundary modes and one-shot FSM states.
package counter_pkg;

  typedef enum logic [1:0] {
    MODE_WRAP    = 2'b00,
    MODE_SAT     = 2'b01,
    MODE_ONESHOT = 2'b10,
    MODE_RSVD    = 2'b11
  } mode_e;

  typedef enum logic {
    OS_ARMED = 1'b0,
    OS_DONE  = 1'b1
  } os_state_e;

endpackage

// File: rtl/updown_mod_counter_if.sv
// Control and status bundle of the up/down modulo counter; master drives controls, slave is the counter.
interface updown_mod_counter_if #(
  parameter int WIDTH = 8
);
  import counter_pkg::*;

  logic             load;
  logic [WIDTH-1:0] data;
  logic             enable;
  logic             up_down;
  logic [WIDTH-1:0] limit;
  mode_e            mode;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             done;

  modport master (
    output load, data, enable, up_down, limit, mode,
    input  count, tc, done
  );

  modport slave (
    input  load, data, enable, up_down, limit, mode,
    output count, tc, done
  );

endinterface

// File: rtl/updown_mod_counter.sv
// Loadable up/down counter with run-time modulo limit and wrap / saturate / one-shot boundary modes.
module updown_mod_counter
  import counter_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int RESET_VAL = 0
) (
  input  logic                clk,
  input  logic                rst,
  updown_mod_counter_if.slave bus
);

  localparam logic [WIDTH-1:0] RESET_COUNT = RESET_VAL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ONE         = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_q, count_next;
  logic             tc_q, tc_next;
  os_state_e        state_q, state_next;

  logic [WIDTH-1:0] stepped;
  logic             at_boundary;
  logic             lands;

  always_comb begin
    count_next = count_q;
    tc_next    = 1'b0;
    state_next = state_q;

    // Counts above limit are treated as "at the top" so an up-step never runs away.
    at_boundary = bus.up_down ? (count_q >= bus.limit) : (count_q == '0);
    stepped     = bus.up_down ? (count_q + ONE) : (count_q - ONE);
    lands       = bus.up_down ? (stepped == bus.limit) : (stepped == '0);

    if (state_q == OS_DONE && bus.mode != MODE_ONESHOT) begin
      state_next = OS_ARMED;
    end

    if (bus.load) begin
      count_next = bus.data;
      state_next = OS_ARMED;
    end else if (bus.enable) begin
      case (bus.mode)
        MODE_SAT: begin
          if (!at_boundary) begin
            count_next = stepped;
            tc_next    = lands;
          end
        end
        MODE_ONESHOT: begin
          // Starting a one-shot already at the boundary finishes it immediately.
          if (state_q == OS_ARMED) begin
            if (at_boundary) begin
              tc_next    = 1'b1;
              state_next = OS_DONE;
            end else begin
              count_next = stepped;
              tc_next    = lands;
              if (lands) begin
                state_next = OS_DONE;
              end
            end
          end
        end
        default: begin
          if (at_boundary) begin
            count_next = bus.up_down ? '0 : bus.limit;
            tc_next    = 1'b1;
          end else begin
            count_next = stepped;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= RESET_COUNT;
      tc_q    <= 1'b0;
      state_q <= OS_ARMED;
    end else begin
      count_q <= count_next;
      tc_q    <= tc_next;
      state_q <= state_next;
    end
  end

  assign bus.count = count_q;
  assign bus.tc    = tc_q;
  assign bus.done  = (state_q == OS_DONE);

endmodule

// File: tb/tb_updown_mod_counter.sv
// Directed bench for updown_mod_counter at WIDTH=4 with hand-computed expectations.
module tb_updown_mod_counter;
  import counter_pkg::*;

  localparam int WIDTH = 4;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  updown_mod_counter_if #(.WIDTH(WIDTH)) bus ();

  updown_mod_counter #(.WIDTH(WIDTH), .RESET_VAL(0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic check_state(input string tag, input int exp_count, input int exp_tc, input int exp_done);
    check({tag, ".count"}, 32'(bus.count), 32'(exp_count));
    check({tag, ".tc"},    32'(bus.tc),    32'(exp_tc));
    check({tag, ".done"},  32'(bus.done),  32'(exp_done));
  endtask

  initial begin
    int sat_cnt [4] = '{2, 1, 0, 0};
    int sat_tc  [4] = '{0, 0, 1, 0};

    rst         = 1'b1;
    bus.load    = 1'b1;
    bus.data    = 4'd5;
    bus.enable  = 1'b0;
    bus.up_down = 1'b1;
    bus.limit   = 4'd9;
    bus.mode    = MODE_WRAP;
    tick();
    tick();
    check_state("reset", 0, 0, 0);

    // WRAP up with limit 9.
    rst      = 1'b0;
    bus.load = 1'b0;
    bus.enable = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      tick();
      check_state($sformatf("wrap_up%0d", i), i, 0, 0);
    end
    tick();
    check_state("wrap_up_rollover", 0, 1, 0);
    tick();
    check_state("wrap_up_after", 1, 0, 0);

    // SAT down from 3.
    bus.mode    = MODE_SAT;
    bus.up_down = 1'b0;
    bus.enable  = 1'b0;
    bus.load    = 1'b1;
    bus.data    = 4'd3;
    tick();
    check_state("sat_load", 3, 0, 0);
    bus.load   = 1'b0;
    bus.enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_state($sformatf("sat_down%0d", i), sat_cnt[i], sat_tc[i], 0);
    end

    // ONESHOT up to 5.
    bus.mode    = MODE_ONESHOT;
    bus.up_down = 1'b1;
    bus.limit   = 4'd5;
    bus.enable  = 1'b0;
    bus.load    = 1'b1;
    bus.data    = 4'd0;
    tick();
    check_state("os_load0", 0, 0, 0);
    bus.load   = 1'b0;
    bus.enable = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check_state($sformatf("os_up%0d", i), i, 0, 0);
    end
    tick();
    check_state("os_hit", 5, 1, 1);
    tick();
    check_state("os_hold1", 5, 0, 1);
    tick();
    check_state("os_hold2", 5, 0, 1);
    bus.enable = 1'b0;
    bus.load   = 1'b1;
    bus.data   = 4'd2;
    tick();
    check_state("os_reload", 2, 0, 0);
    bus.load   = 1'b0;
    bus.enable = 1'b1;
    tick();
    check_state("os_resume", 3, 0, 0);
    tick();
    tick();
    check_state("os_hit2", 5, 1, 1);

    // Leaving ONESHOT while DONE rearms the FSM.
    bus.enable = 1'b0;
    bus.mode   = MODE_WRAP;
    tick();
    check_state("mode_leave", 5, 0, 0);

    // Load wins over a simultaneous enable, even above limit.
    bus.limit  = 4'd9;
    bus.load   = 1'b1;
    bus.enable = 1'b1;
    bus.data   = 4'd12;
    tick();
    check_state("load_enable", 12, 0, 0);
    bus.load = 1'b0;
    tick();
    check_state("above_limit_wrap", 0, 1, 0);

    // WRAP down from 0 goes to limit.
    bus.up_down = 1'b0;
    tick();
    check_state("wrap_down", 9, 1, 0);
    tick();
    check_state("wrap_down_next", 8, 0, 0);

    // limit 0 in WRAP up pins count at 0 with tc every cycle.
    bus.up_down = 1'b1;
    bus.limit   = 4'd0;
    bus.load    = 1'b1;
    bus.enable  = 1'b0;
    bus.data    = 4'd0;
    tick();
    bus.load   = 1'b0;
    bus.enable = 1'b1;
    tick();
    check_state("limit0_a", 0, 1, 0);
    tick();
    check_state("limit0_b", 0, 1, 0);

    // SAT up pinned at limit produces a single tc.
    bus.mode   = MODE_SAT;
    bus.limit  = 4'd3;
    bus.load   = 1'b1;
    bus.data   = 4'd2;
    bus.enable = 1'b0;
    tick();
    bus.load   = 1'b1;
    bus.load   = 1'b0;
    bus.enable = 1'b1;
    tick();
    check_state("sat_up_hit", 3, 1, 0);
    tick();
    check_state("sat_up_pinned", 3, 0, 0);

    // Reset while DONE.
    bus.mode   = MODE_ONESHOT;
    bus.limit  = 4'd5;
    bus.load   = 1'b1;
    bus.data   = 4'd4;
    bus.enable = 1'b0;
    tick();
    bus.load   = 1'b0;
    bus.enable = 1'b1;
    tick();
    check_state("os_done_pre_rst", 5, 1, 1);
    rst = 1'b1;
    tick();
    check_state("rst_in_done", 0, 0, 0);
    rst = 1'b0;
    tick();
    check_state("after_rst", 1, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
